// File: rtl/gxl01_deserializer_if.sv
// Bus bundle for the GXL-01 serial-to-parallel receiver.
// Define GXL01_DESER_OVERRUN_EN to add the sticky OVERRUN flag.
interface gxl01_deserializer_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 8
);
  logic [1:0]             MODE;
  logic                   BITSEL;
  logic                   SYNC;
  logic [LANES-1:0]       SER_IN;
  logic                   PAR_READY;
  logic [LANES*WIDTH-1:0] PAR_OUT;
  logic                   PAR_VALID;
  logic                   BUSY;
`ifdef GXL01_DESER_OVERRUN_EN
  logic                   OVERRUN;
`endif

  // Handshake: a word is accepted on any rising edge where PAR_VALID=1 and
  // PAR_READY=1; PAR_OUT is stable while PAR_VALID=1 unless a new word overruns it.
  modport master (
    output MODE, BITSEL, SYNC, SER_IN, PAR_READY,
`ifdef GXL01_DESER_OVERRUN_EN
    input  OVERRUN,
`endif
    input  PAR_OUT, PAR_VALID, BUSY
  );

  modport slave (
    input  MODE, BITSEL, SYNC, SER_IN, PAR_READY,
`ifdef GXL01_DESER_OVERRUN_EN
    output OVERRUN,
`endif
    output PAR_OUT, PAR_VALID, BUSY
  );
endinterface

// File: rtl/gxl01_deserializer.sv
// Multi-lane serial-in/parallel-out receiver with a valid/ready holding register.
// Optional macro GXL01_DESER_OVERRUN_EN adds a sticky OVERRUN flag.
module gxl01_deserializer #(
  parameter int LANES = 4,
  parameter int WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST_n,
  gxl01_deserializer_if.slave    bus
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [LANES-1:0][WIDTH-1:0] r_shift;
  logic [CW-1:0]               r_cnt;
  logic                        r_order;
  logic [LANES-1:0][WIDTH-1:0] r_par_out;
  logic                        r_par_valid;

  logic [LANES-1:0][WIDTH-1:0] w_nxt_shift;
  logic [CW-1:0]               w_nxt_cnt;
  logic                        w_nxt_order;
  logic                        w_order_use;
  logic [CW-1:0]               w_cnt_base;
  logic [LANES-1:0][WIDTH-1:0] w_shifted;
  logic                        w_xfer;
  logic [LANES-1:0][WIDTH-1:0] w_xfer_word;

  function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] word,
                                               input logic bit_in,
                                               input logic lsb_first);
    if (lsb_first) return (word >> 1) | (WIDTH'(bit_in) << (WIDTH - 1));
    else           return (word << 1) | WIDTH'(bit_in);
  endfunction

  always_comb begin
    w_nxt_shift = r_shift;
    w_nxt_cnt   = r_cnt;
    w_nxt_order = r_order;
    w_order_use = r_order;
    w_cnt_base  = r_cnt;
    w_shifted   = '0;
    w_xfer      = 1'b0;
    w_xfer_word = '0;
    case (bus.MODE)
      2'b10: begin
        w_nxt_shift = '0;
        w_nxt_cnt   = '0;
      end
      2'b11: begin
        if (r_cnt != '0) begin
          w_xfer      = 1'b1;
          w_xfer_word = r_shift;
          w_nxt_shift = '0;
          w_nxt_cnt   = '0;
        end
      end
      2'b01: begin
        // SYNC behaves as a shift into an empty shifter at count 0.
        w_cnt_base  = bus.SYNC ? '0 : r_cnt;
        w_order_use = (w_cnt_base == '0) ? bus.BITSEL : r_order;
        w_nxt_order = w_order_use;
        for (int n = 0; n < LANES; n++) begin
          w_shifted[n] = f_shift(bus.SYNC ? {WIDTH{1'b0}} : r_shift[n],
                                 bus.SER_IN[n], w_order_use);
        end
        if (w_cnt_base == CW'(WIDTH - 1)) begin
          w_xfer      = 1'b1;
          w_xfer_word = w_shifted;
          w_nxt_shift = '0;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_shift = w_shifted;
          w_nxt_cnt   = w_cnt_base + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_order <= 1'b0;
    end else begin
      r_shift <= w_nxt_shift;
      r_cnt   <= w_nxt_cnt;
      r_order <= w_nxt_order;
    end
  end

  // A new word always wins over an accept on the same edge.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_par_out   <= '0;
      r_par_valid <= 1'b0;
    end else if (w_xfer) begin
      r_par_out   <= w_xfer_word;
      r_par_valid <= 1'b1;
    end else if (r_par_valid && bus.PAR_READY) begin
      r_par_valid <= 1'b0;
    end
  end

`ifdef GXL01_DESER_OVERRUN_EN
  logic r_overrun;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)                                           r_overrun <= 1'b0;
    else if (bus.MODE == 2'b10)                           r_overrun <= 1'b0;
    else if (w_xfer && r_par_valid && !bus.PAR_READY)     r_overrun <= 1'b1;
  end

  assign bus.OVERRUN = r_overrun;
`endif

  assign bus.PAR_OUT   = r_par_out;
  assign bus.PAR_VALID = r_par_valid;
  assign bus.BUSY      = (r_cnt != '0);
endmodule

// File: tb/tb_gxl01_deserializer.sv
// Directed self-checking bench for gxl01_deserializer (LANES=4, WIDTH=8).
module tb_gxl01_deserializer;
  localparam int LANES = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gxl01_deserializer_if #(.LANES(LANES), .WIDTH(WIDTH)) bus();

  gxl01_deserializer #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .CLK   (clk),
    .RST_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream bits first..first+n-1 of each pattern; pattern bit 7 goes out first.
  task automatic send_bits(input logic [7:0] l0, input logic [7:0] lo,
                           input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      bus.MODE   = 2'b01;
      bus.SER_IN = {lo[7-i], lo[7-i], lo[7-i], l0[7-i]};
      tick();
    end
    bus.MODE   = 2'b00;
    bus.SER_IN = '0;
  endtask

  task automatic accept();
    bus.MODE      = 2'b00;
    bus.PAR_READY = 1'b1;
    tick();
    bus.PAR_READY = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.MODE      = 2'b00;
    bus.BITSEL    = 1'b0;
    bus.SYNC      = 1'b0;
    bus.SER_IN    = '0;
    bus.PAR_READY = 1'b0;
    tick();
    tick();
    checks++; if (bus.PAR_OUT !== 32'h0) begin errors++; $display("FAIL reset_out got %h want %h", bus.PAR_OUT, 32'h0); end
    checks++; if (bus.PAR_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.PAR_VALID); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.BUSY); end
`ifdef GXL01_DESER_OVERRUN_EN
    checks++; if (bus.OVERRUN !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", bus.OVERRUN); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_msb_first();
    bus.BITSEL = 1'b0;
    send_bits(8'hA5, 8'hF0, 0, 4);
    checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL msb_busy4 got %b want 1", bus.BUSY); end
    tick();
    tick();
    checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL msb_hold_busy got %b want 1", bus.BUSY); end
    send_bits(8'hA5, 8'hF0, 4, 3);
    checks++; if (bus.PAR_VALID !== 1'b0) begin errors++; $display("FAIL msb_valid7 got %b want 0", bus.PAR_VALID); end
    send_bits(8'hA5, 8'hF0, 7, 1);
    checks++; if (bus.PAR_OUT !== 32'hF0F0F0A5) begin errors++; $display("FAIL msb_word got %h want %h", bus.PAR_OUT, 32'hF0F0F0A5); end
    checks++; if (bus.PAR_VALID !== 1'b1) begin errors++; $display("FAIL msb_valid got %b want 1", bus.PAR_VALID); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL msb_busy_end got %b want 0", bus.BUSY); end
    accept();
    checks++; if (bus.PAR_VALID !== 1'b0) begin errors++; $display("FAIL msb_accept got %b want 0", bus.PAR_VALID); end
  endtask

  task automatic test_lsb_first();
    bus.BITSEL = 1'b1;
    send_bits(8'hA5, 8'hF0, 0, 8);
    checks++; if (bus.PAR_OUT !== 32'h0F0F0FA5) begin errors++; $display("FAIL lsb_word got %h want %h", bus.PAR_OUT, 32'h0F0F0FA5); end
    accept();
    send_bits(8'hC0, 8'h00, 0, 3);
    bus.BITSEL = 1'b0;
    send_bits(8'hC0, 8'h00, 3, 5);
    checks++; if (bus.PAR_OUT !== 32'h00000003) begin errors++; $display("FAIL lsb_order_hold got %h want %h", bus.PAR_OUT, 32'h00000003); end
    checks++; if (bus.PAR_VALID !== 1'b1) begin errors++; $display("FAIL lsb_valid got %b want 1", bus.PAR_VALID); end
    accept();
  endtask

  task automatic test_sync();
    bus.BITSEL = 1'b0;
    send_bits(8'hFF, 8'hFF, 0, 5);
    bus.MODE   = 2'b01;
    bus.SYNC   = 1'b1;
    bus.SER_IN = 4'b0001;
    tick();
    bus.SYNC   = 1'b0;
    bus.MODE   = 2'b00;
    bus.SER_IN = '0;
    checks++; if (bus.PAR_VALID !== 1'b0) begin errors++; $display("FAIL sync_no_xfer got %b want 0", bus.PAR_VALID); end
    checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL sync_busy got %b want 1", bus.BUSY); end
    send_bits(8'h00, 8'h00, 0, 6);
    checks++; if (bus.PAR_VALID !== 1'b0) begin errors++; $display("FAIL sync_early got %b want 0", bus.PAR_VALID); end
    send_bits(8'h00, 8'h00, 0, 1);
    checks++; if (bus.PAR_OUT !== 32'h00000080) begin errors++; $display("FAIL sync_word got %h want %h", bus.PAR_OUT, 32'h00000080); end
    checks++; if (bus.PAR_VALID !== 1'b1) begin errors++; $display("FAIL sync_valid got %b want 1", bus.PAR_VALID); end
    accept();
  endtask

  task automatic test_flush_clear();
    send_bits(8'hE0, 8'h00, 0, 3);
    bus.MODE = 2'b11;
    tick();
    bus.MODE = 2'b00;
    checks++; if (bus.PAR_OUT !== 32'h00000007) begin errors++; $display("FAIL flush_word got %h want %h", bus.PAR_OUT, 32'h00000007); end
    checks++; if (bus.PAR_VALID !== 1'b1) begin errors++; $display("FAIL flush_valid got %b want 1", bus.PAR_VALID); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", bus.BUSY); end
    accept();
    send_bits(8'hE0, 8'hE0, 0, 3);
    bus.MODE = 2'b10;
    tick();
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL clear_busy got %b want 0", bus.BUSY); end
    bus.MODE = 2'b11;
    tick();
    bus.MODE = 2'b00;
    checks++; if (bus.PAR_VALID !== 1'b0) begin errors++; $display("FAIL empty_flush_valid got %b want 0", bus.PAR_VALID); end
    checks++; if (bus.PAR_OUT !== 32'h00000007) begin errors++; $display("FAIL empty_flush_out got %h want %h", bus.PAR_OUT, 32'h00000007); end
  endtask

  task automatic test_overrun();
    bus.PAR_READY = 1'b0;
    send_bits(8'h11, 8'h00, 0, 8);
    checks++; if (bus.PAR_OUT !== 32'h00000011) begin errors++; $display("FAIL ovr_first got %h want %h", bus.PAR_OUT, 32'h00000011); end
    send_bits(8'h22, 8'h00, 0, 8);
    checks++; if (bus.PAR_OUT !== 32'h00000022) begin errors++; $display("FAIL ovr_second got %h want %h", bus.PAR_OUT, 32'h00000022); end
    checks++; if (bus.PAR_VALID !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", bus.PAR_VALID); end
`ifdef GXL01_DESER_OVERRUN_EN
    checks++; if (bus.OVERRUN !== 1'b1) begin errors++; $display("FAIL ovr_flag_set got %b want 1", bus.OVERRUN); end
`endif
    accept();
    checks++; if (bus.PAR_VALID !== 1'b0) begin errors++; $display("FAIL ovr_accept got %b want 0", bus.PAR_VALID); end
`ifdef GXL01_DESER_OVERRUN_EN
    checks++; if (bus.OVERRUN !== 1'b1) begin errors++; $display("FAIL ovr_flag_sticky got %b want 1", bus.OVERRUN); end
    bus.MODE = 2'b10;
    tick();
    bus.MODE = 2'b00;
    checks++; if (bus.OVERRUN !== 1'b0) begin errors++; $display("FAIL ovr_flag_clear got %b want 0", bus.OVERRUN); end
`endif
  endtask

  task automatic test_back_to_back();
    send_bits(8'h33, 8'h00, 0, 8);
    send_bits(8'h44, 8'h00, 0, 7);
    checks++; if (bus.PAR_OUT !== 32'h00000033) begin errors++; $display("FAIL b2b_hold got %h want %h", bus.PAR_OUT, 32'h00000033); end
    bus.PAR_READY = 1'b1;
    send_bits(8'h44, 8'h00, 7, 1);
    bus.PAR_READY = 1'b0;
    checks++; if (bus.PAR_OUT !== 32'h00000044) begin errors++; $display("FAIL b2b_word got %h want %h", bus.PAR_OUT, 32'h00000044); end
    checks++; if (bus.PAR_VALID !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", bus.PAR_VALID); end
`ifdef GXL01_DESER_OVERRUN_EN
    checks++; if (bus.OVERRUN !== 1'b0) begin errors++; $display("FAIL b2b_no_overrun got %b want 0", bus.OVERRUN); end
`endif
    accept();
    checks++; if (bus.PAR_VALID !== 1'b0) begin errors++; $display("FAIL b2b_accept got %b want 0", bus.PAR_VALID); end
  endtask

  task automatic test_async_reset();
    bus.BITSEL = 1'b0;
    send_bits(8'h55, 8'h00, 0, 8);
    send_bits(8'h0F, 8'h0F, 0, 4);
    checks++; if (bus.BUSY !== 1'b1 || bus.PAR_VALID !== 1'b1) begin errors++; $display("FAIL arst_pre got busy %b valid %b want 1 1", bus.BUSY, bus.PAR_VALID); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.PAR_OUT !== 32'h0) begin errors++; $display("FAIL arst_out got %h want %h", bus.PAR_OUT, 32'h0); end
    checks++; if (bus.PAR_VALID !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", bus.PAR_VALID); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", bus.BUSY); end
    #3 rst_n = 1'b1;
    send_bits(8'h5A, 8'hF0, 0, 8);
    checks++; if (bus.PAR_OUT !== 32'hF0F0F05A) begin errors++; $display("FAIL arst_clean_word got %h want %h", bus.PAR_OUT, 32'hF0F0F05A); end
    checks++; if (bus.PAR_VALID !== 1'b1) begin errors++; $display("FAIL arst_clean_valid got %b want 1", bus.PAR_VALID); end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_sync();
    test_flush_clear();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
